// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART controller: register offsets,
// STATUS field positions and a helper that assembles the STATUS word.
// Pure declarations, no logic, no latency, no backpressure.
package uart_pkg;

    // Byte offsets inside the 32-byte register window.
    localparam logic [4:0] UART_TX_CTRL = 5'h00;
    localparam logic [4:0] UART_RX_CTRL = 5'h04;
    localparam logic [4:0] UART_TX_DATA = 5'h08;
    localparam logic [4:0] UART_RX_DATA = 5'h0C;
    localparam logic [4:0] UART_STATUS  = 5'h10;

    // STATUS register bit layout.
    localparam int ST_TX_OVF     = 0;
    localparam int ST_RX_UNF     = 1;
    localparam int ST_TX_CNT_LSB = 2;
    localparam int ST_TX_CNT_W   = 6;
    localparam int ST_RX_CNT_LSB = 8;
    localparam int ST_RX_CNT_W   = 8;

    function automatic logic [31:0] pack_status(
        input logic [ST_RX_CNT_W-1:0] rx_cnt,
        input logic [ST_TX_CNT_W-1:0] tx_cnt,
        input logic                   rx_unf,
        input logic                   tx_ovf
    );
        logic [31:0] s;
        s = '0;
        s[ST_RX_CNT_LSB +: ST_RX_CNT_W] = rx_cnt;
        s[ST_TX_CNT_LSB +: ST_TX_CNT_W] = tx_cnt;
        s[ST_RX_UNF]                    = rx_unf;
        s[ST_TX_OVF]                    = tx_ovf;
        return s;
    endfunction

endpackage

// File: rtl/uart_mmio_fifo_if.sv
// Bundles the CPU memory-stage bus and the UART TX/RX byte handshakes.
// Wires only, no latency; valid/ready on both byte streams.
// master = CPU + UART side, slave = the controller.
interface uart_mmio_fifo_if #(
    parameter int DATA_W = 8
);
    // CPU memory stage
    logic [31:0]       Addr;
    logic              MemRead;
    logic              MemWrite;
    logic [31:0]       WriteData;
    logic [31:0]       ReadData;
    logic              Hit;
    // Towards the UART transmitter
    logic [DATA_W-1:0] DataIn;
    logic              DataInValid;
    logic              DataInReady;
    // From the UART receiver
    logic [DATA_W-1:0] DataOut;
    logic              DataOutValid;
    logic              DataOutReady;

    modport master (
        output Addr, MemRead, MemWrite, WriteData, DataInReady, DataOut, DataOutValid,
        input  ReadData, Hit, DataIn, DataInValid, DataOutReady
    );

    modport slave (
        input  Addr, MemRead, MemWrite, WriteData, DataInReady, DataOut, DataOutValid,
        output ReadData, Hit, DataIn, DataInValid, DataOutReady
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head visible combinationally on dout.
// Latency: a push at edge N is visible on dout/empty after edge N.
// Backpressure: push ignored when full, pop ignored when empty (pre-edge state).
// Ports: push/din write side, pop/dout read side, full/empty/count status.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,     // async, active low
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);

    // Storage is deliberately not reset; pointers and count define validity.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointers wrap naturally.
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART controller: TX/RX FIFOs, 32-byte register window, sticky errors.
// Latency: ReadData/Hit combinational; push/pop/flag updates commit at next edge.
// Backpressure: TX push when full is dropped (tx_ovf); RX ready low when full.
// Ports: clk, rst (async active low), bus = uart_mmio_fifo_if.slave.
module uart_mmio_fifo
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          TX_DEPTH  = 8,
    parameter int          RX_DEPTH  = 8,
    parameter int          DATA_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_mmio_fifo_if.slave       bus
);

    localparam int TX_CW = $clog2(TX_DEPTH + 1);
    localparam int RX_CW = $clog2(RX_DEPTH + 1);

    logic [4:0]        offset;
    logic              in_window;
    logic              is_store;
    logic              is_load;

    logic              tx_push_req;
    logic              tx_full, tx_empty;
    logic [DATA_W-1:0] tx_dout;
    logic [TX_CW-1:0]  tx_count;

    logic              rx_push;
    logic              rx_pop_req;
    logic              rx_full, rx_empty;
    logic [DATA_W-1:0] rx_dout;
    logic [RX_CW-1:0]  rx_count;

    logic              tx_ovf_q, tx_ovf_d;
    logic              rx_unf_q, rx_unf_d;
    logic [31:0]       read_dat;

    // Upper store-data bits beyond the character width have no destination.
    logic              unused_wdat;
    assign unused_wdat = ^bus.WriteData[31:DATA_W];

    // ---------------------------------------------------------------- decode
    assign offset    = bus.Addr[4:0];
    assign in_window = (bus.Addr[31:5] == BASE_ADDR[31:5]);
    // A cycle with both strobes is a store, never a load.
    assign is_store  = in_window & bus.MemWrite;
    assign is_load   = in_window & bus.MemRead & ~bus.MemWrite;
    assign bus.Hit   = in_window & (bus.MemRead | bus.MemWrite);

    assign tx_push_req = is_store & (offset == UART_TX_DATA);
    assign rx_pop_req  = is_load  & (offset == UART_RX_DATA);
    assign rx_push     = bus.DataOutValid & ~rx_full;

    // ---------------------------------------------------------------- FIFOs
    // Full/empty gating (dropped TX push, no pop on empty) lives in sync_fifo.
    sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH), .CW(TX_CW)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push_req),
        .pop   (bus.DataInReady),
        .din   (bus.WriteData[DATA_W-1:0]),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH), .CW(RX_CW)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop_req),
        .din   (bus.DataOut),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // Storage is unreset, so mask the head while empty to keep DataIn at zero.
    assign bus.DataIn       = tx_empty ? '0 : tx_dout;
    assign bus.DataInValid  = ~tx_empty;
    assign bus.DataOutReady = ~rx_full;

    // ---------------------------------------------------------------- sticky flags
    always_comb begin
        tx_ovf_d = tx_ovf_q;
        rx_unf_d = rx_unf_q;
        if (is_store && offset == UART_STATUS) begin
            if (bus.WriteData[ST_TX_OVF]) tx_ovf_d = 1'b0;
            if (bus.WriteData[ST_RX_UNF]) rx_unf_d = 1'b0;
        end
        // Setting after clearing makes a same-cycle set win.
        if (tx_push_req && tx_full) tx_ovf_d = 1'b1;
        if (rx_pop_req && rx_empty) rx_unf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
            rx_unf_q <= rx_unf_d;
        end
    end

    // ---------------------------------------------------------------- read mux
    always_comb begin
        read_dat = '0;
        if (is_load) begin
            case (offset)
                UART_TX_CTRL: read_dat = {31'b0, ~tx_full};
                UART_RX_CTRL: read_dat = {31'b0, ~rx_empty};
                UART_RX_DATA: read_dat = rx_empty ? 32'b0 : 32'(rx_dout);
                UART_STATUS:  read_dat = pack_status(ST_RX_CNT_W'(rx_count),
                                                     ST_TX_CNT_W'(tx_count),
                                                     rx_unf_q, tx_ovf_q);
                default:      read_dat = '0;
            endcase
        end
    end

    assign bus.ReadData = read_dat;

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Self-checking bench for uart_mmio_fifo: queue-based reference model,
// per-cycle compare on the falling edge, directed scenarios with literal
// expectations, then a long randomized run.
module tb_uart_mmio_fifo;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int TXD = 8;
    localparam int RXD = 8;
    localparam int DW  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_mmio_fifo_if #(.DATA_W(DW)) bus ();

    uart_mmio_fifo #(
        .BASE_ADDR (BASE),
        .TX_DEPTH  (TXD),
        .RX_DEPTH  (RXD),
        .DATA_W    (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ reference model
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit         m_ovf;
    bit         m_unf;

    function automatic bit in_win(input logic [31:0] a);
        return (a & 32'hFFFF_FFE0) == BASE;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_q.delete();
            rx_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            bit win, st, ld, tx_pop, tx_push, tx_drop, rx_push, rx_rd;
            logic [4:0] off;
            win     = in_win(bus.Addr);
            off     = bus.Addr[4:0];
            st      = win && bus.MemWrite;
            ld      = win && bus.MemRead && !bus.MemWrite;
            tx_pop  = (tx_q.size() != 0) && bus.DataInReady;
            tx_push = st && (off == 5'h08);
            tx_drop = tx_push && (tx_q.size() == TXD);
            rx_push = bus.DataOutValid && (rx_q.size() < RXD);
            rx_rd   = ld && (off == 5'h0C);
            if (st && off == 5'h10) begin
                if (bus.WriteData[0]) m_ovf = 1'b0;
                if (bus.WriteData[1]) m_unf = 1'b0;
            end
            if (tx_drop) m_ovf = 1'b1;
            if (rx_rd && rx_q.size() == 0) m_unf = 1'b1;
            if (tx_pop) void'(tx_q.pop_front());
            if (tx_push && !tx_drop) tx_q.push_back(bus.WriteData[7:0]);
            if (rx_rd && rx_q.size() != 0) void'(rx_q.pop_front());
            if (rx_push) rx_q.push_back(bus.DataOut);
        end
    end

    // ------------------------------------------------------------ per-cycle compare
    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] exp_rd;
            logic [4:0]  off;
            bit          win, ld;
            win    = in_win(bus.Addr);
            off    = bus.Addr[4:0];
            ld     = win && bus.MemRead && !bus.MemWrite;
            exp_rd = 32'h0;
            if (ld) begin
                case (off)
                    5'h00:   exp_rd = (tx_q.size() < TXD) ? 32'h1 : 32'h0;
                    5'h04:   exp_rd = (rx_q.size() != 0) ? 32'h1 : 32'h0;
                    5'h0C:   exp_rd = (rx_q.size() != 0) ? 32'(rx_q[0]) : 32'h0;
                    5'h10:   exp_rd = 32'(rx_q.size() * 256 + tx_q.size() * 4 + int'(m_unf) * 2 + int'(m_ovf));
                    default: exp_rd = 32'h0;
                endcase
            end
            check("Hit",          32'(bus.Hit), 32'(win && (bus.MemRead || bus.MemWrite)));
            check("ReadData",     bus.ReadData, exp_rd);
            check("DataInValid",  32'(bus.DataInValid), 32'(tx_q.size() != 0));
            check("DataIn",       32'(bus.DataIn), (tx_q.size() != 0) ? 32'(tx_q[0]) : 32'h0);
            check("DataOutReady", 32'(bus.DataOutReady), 32'(rx_q.size() < RXD));
        end
    end

    // ------------------------------------------------------------ stimulus helpers
    task automatic idle_bus();
        bus.Addr      = 32'h0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.WriteData = 32'h0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic store(input logic [4:0] off, input logic [31:0] wd);
        bus.Addr      = BASE + 32'(off);
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b1;
        bus.WriteData = wd;
        tick(1);
        idle_bus();
    endtask

    task automatic load(input logic [4:0] off, output logic [31:0] rd);
        bus.Addr     = BASE + 32'(off);
        bus.MemRead  = 1'b1;
        bus.MemWrite = 1'b0;
        @(negedge clk);
        rd = bus.ReadData;
        @(posedge clk);
        #1;
        idle_bus();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ main sequence
    initial begin
        logic [31:0] r;
        idle_bus();
        bus.DataInReady  = 1'b0;
        bus.DataOut      = 8'h00;
        bus.DataOutValid = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b1;
        chk_en = 1'b1;

        // Reset then idle
        load(5'h10, r); check("reset STATUS", r, 32'h0);
        load(5'h00, r); check("reset TX_CTRL", r, 32'h1);
        load(5'h04, r); check("reset RX_CTRL", r, 32'h0);
        check("reset DataInValid", 32'(bus.DataInValid), 32'h0);
        check("reset DataOutReady", 32'(bus.DataOutReady), 32'h1);

        // Three bytes queued, then drained back to back
        store(5'h08, 32'h41);
        store(5'h08, 32'h42);
        store(5'h08, 32'h43);
        load(5'h10, r); check("tx_count 3", r, 32'h0000_000C);
        bus.DataInReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("drain DataIn", 32'(bus.DataIn), 32'h41 + 32'(i));
        end
        @(negedge clk);
        check("drain done valid", 32'(bus.DataInValid), 32'h0);
        @(posedge clk);
        #1;
        bus.DataInReady = 1'b0;

        // Overflow: 9 stores into an 8-deep FIFO
        for (int i = 0; i < 9; i++) store(5'h08, 32'h50 + 32'(i));
        load(5'h10, r); check("tx overflow STATUS", r, 32'h0000_0021);
        load(5'h00, r); check("tx full TX_CTRL", r, 32'h0);
        store(5'h10, 32'h1);
        load(5'h10, r); check("tx_ovf cleared", r, 32'h0000_0020);
        bus.DataInReady = 1'b1;
        tick(9);
        bus.DataInReady = 1'b0;
        load(5'h10, r); check("tx drained", r, 32'h0);

        // RX fill to full, read back, then underflow
        for (int i = 0; i < 8; i++) begin
            bus.DataOutValid = 1'b1;
            bus.DataOut      = 8'(16 + i);
            tick(1);
        end
        bus.DataOutValid = 1'b0;
        check("rx full ready low", 32'(bus.DataOutReady), 32'h0);
        load(5'h04, r); check("rx nonempty RX_CTRL", r, 32'h1);
        for (int i = 0; i < 8; i++) begin
            load(5'h0C, r); check("rx data order", r, 32'h10 + 32'(i));
        end
        load(5'h0C, r); check("rx underflow data", r, 32'h0);
        load(5'h10, r); check("rx_unf STATUS", r, 32'h0000_0002);
        store(5'h10, 32'h2);
        load(5'h10, r); check("rx_unf cleared", r, 32'h0);

        // TX full with a pop and a push in the same cycle
        for (int i = 0; i < 8; i++) store(5'h08, 32'h60 + 32'(i));
        bus.DataInReady = 1'b1;
        store(5'h08, 32'h99);
        bus.DataInReady = 1'b0;
        load(5'h10, r); check("full pop+push STATUS", r, 32'h0000_001D);
        check("head after pop", 32'(bus.DataIn), 32'h61);
        store(5'h10, 32'h1);
        bus.DataInReady = 1'b1;
        tick(8);
        bus.DataInReady = 1'b0;

        // RX with 3 entries: push and pop together keep the count
        for (int i = 0; i < 3; i++) begin
            bus.DataOutValid = 1'b1;
            bus.DataOut      = 8'(32 + i);
            tick(1);
        end
        bus.DataOut = 8'h23;
        load(5'h0C, r); check("rx pop during push", r, 32'h20);
        bus.DataOutValid = 1'b0;
        load(5'h10, r); check("rx count stays 3", r, 32'h0000_0300);
        for (int i = 0; i < 3; i++) begin
            load(5'h0C, r); check("rx after push+pop", r, 32'h21 + 32'(i));
        end

        // Reset asserted mid-drain
        for (int i = 0; i < 5; i++) store(5'h08, 32'h70 + 32'(i));
        bus.DataInReady = 1'b1;
        @(posedge clk);
        #3;
        bus.Addr    = BASE + 32'h10;
        bus.MemRead = 1'b1;
        rst         = 1'b0;
        #1;
        check("mid-reset DataInValid", 32'(bus.DataInValid), 32'h0);
        check("mid-reset DataIn", 32'(bus.DataIn), 32'h0);
        check("mid-reset STATUS", bus.ReadData, 32'h0);
        idle_bus();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no stale byte", 32'(bus.DataInValid), 32'h0);
        end
        @(posedge clk);
        #1;
        bus.DataInReady = 1'b0;

        // Randomized traffic, alternating fill-biased and drain-biased phases
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] off;
            bit         fill;
            fill = ((c / 300) % 2) == 0;
            case ($urandom_range(0, 6))
                0:       off = 5'h00;
                1:       off = 5'h04;
                2, 3:    off = 5'h08;
                4:       off = 5'h0C;
                5:       off = 5'h10;
                default: off = 5'($urandom);
            endcase
            bus.Addr         = ($urandom_range(0, 9) == 0) ? 32'($urandom) : BASE + 32'(off);
            bus.MemRead      = ($urandom_range(0, 2) == 0);
            bus.MemWrite     = ($urandom_range(0, 2) == 0);
            bus.WriteData    = 32'($urandom);
            bus.DataInReady  = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            bus.DataOutValid = fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            bus.DataOut      = 8'($urandom);
            tick(1);
        end

        idle_bus();
        bus.DataInReady  = 1'b0;
        bus.DataOutValid = 1'b0;
        tick(2);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_mmio_fifo.md
Name: uart_mmio_fifo

Overview:
- Memory-mapped UART controller with parametrised TX and RX FIFOs between the CPU memory stage and the UART transmitter/receiver.
- Decodes load/store accesses in a configurable base-address window.
- Buffers up to TX_DEPTH outgoing and RX_DEPTH incoming bytes, so software need not poll per byte.
- Adds occupancy counts and sticky error flags with write-1-to-clear.

Parameters:
- BASE_ADDR, 32'h8000_0000, base of the 32-byte register window; bits [4:0] must be zero.
- TX_DEPTH, 8, TX FIFO entries; power of two, >= 2.
- RX_DEPTH, 8, RX FIFO entries; power of two, >= 2.
- DATA_W, 8, UART character width; 5..8.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset: asserted at 0, released synchronously to clk.
- Addr  in  32  memory-stage byte address.
- MemRead  in  1  load in memory stage this cycle.
- MemWrite  in  1  store in memory stage this cycle.
- WriteData  in  32  store data.
- ReadData  out  32  load result when Hit=1, else 0.
- Hit  out  1  Addr is inside the window and (MemRead | MemWrite).
- DataIn  out  DATA_W  byte to UART TX.
- DataInValid  out  1  TX FIFO non-empty.
- DataInReady  in  1  UART TX accepts.
- DataOut  in  DATA_W  byte from UART RX.
- DataOutValid  in  1  UART RX has byte.
- DataOutReady  out  1  RX FIFO not full.

Behaviour:
- Register map, byte offsets from BASE_ADDR (all other offsets: Hit=1, ReadData=0, writes ignored):
  - 0x00 R: {31'b0, !tx_full}.
  - 0x04 R: {31'b0, !rx_empty}.
  - 0x08 W: push WriteData[DATA_W-1:0] into TX FIFO.
  - 0x0C R: pop RX FIFO; data zero-extended.
  - 0x10 R: {16'b0, rx_count[7:0], tx_count[5:0], rx_unf, tx_ovf}. W: write-1-to-clear; WriteData[0] clears tx_ovf, WriteData[1] clears rx_unf.
- MemRead and MemWrite both high: treat as a store.
- ReadData and Hit are combinational, valid in the same cycle as the access. The pop, push and flag updates commit at the next rising edge.
- TX push when full: byte dropped, tx_ovf set. The full test uses the pre-edge state, so a TX pop in the same cycle does not rescue the push.
- TX drain:
  - DataIn = TX head; DataInValid = !tx_empty.
  - Pop on DataInValid & DataInReady.
  - A byte stored at edge N appears on DataInValid after edge N (no bypass).
- RX fill: DataOutReady = !rx_full; push on DataOutValid & DataOutReady. The UART holds the byte while ready is low; no RX drop is possible.
- RX data read when empty: ReadData=0, rx_unf set, no pop. No bypass from a same-cycle push.
- Simultaneous push and pop on one FIFO: both happen, count unchanged.
  - TX full + pop + push: push dropped, count becomes DEPTH-1.
  - RX full + pop + DataOutValid: ready is low, so only the pop happens.
- Sticky flag set and write-1-clear in the same cycle: set wins.
- Pointers are log2(DEPTH) bits with natural wrap. Counts are $clog2(DEPTH+1) bits, zero-extended into the status field.
- Reset values (rst low, asynchronous):
  - pointers, counts, tx_ovf, rx_unf = 0.
  - DataInValid=0, DataOutReady=1 after release; DataIn=0.
  - FIFO storage is not reset.
- Reset mid-transfer: FIFO contents discarded, DataInValid drops immediately.

Decomposition:
- Shared package uart_pkg:
  - register offsets UART_TX_CTRL/RX_CTRL/TX_DATA/RX_DATA/STATUS;
  - status bit indices.
- One sub-module sync_fifo (params WIDTH, DEPTH; ports push/pop/din/dout/full/empty/count), instantiated for TX and RX.
- Address decode and flag logic stay in the top.

Test Plan:
- Reset then idle: STATUS read = 0x0000_0000, offset 0x00 reads 1, offset 0x04 reads 0, DataInValid=0, DataOutReady=1.
- Store 0x41,0x42,0x43 to 0x08 with DataInReady=0: tx_count=3. Then DataInReady=1: DataIn shows 0x41,0x42,0x43 on consecutive cycles, then DataInValid=0.
- 9 stores with TX_DEPTH=8, DataInReady=0: 9th byte dropped, STATUS=0x21. Write 1 to STATUS: reads 0x20.
- Feed 8 RX bytes 0x10..0x17: DataOutReady low after the 8th. Reads of 0x0C return 0x10..0x17 in order; 9th read returns 0 with rx_unf=1.
- TX full, DataInReady=1, store same cycle: count goes to 7, tx_ovf=1. RX with count 3, push+pop same cycle: count stays 3.
- Assert rst low mid-drain with 5 TX bytes queued: DataInValid=0 and counts=0 with no clock edge required. After release, no stale byte is transmitted.
